sparrow_lsu: RTL and testbench

Load/store unit for the sparrow core. Consumes the memory fields of `control_t` (`data_req`, `data_wr`, `data_byte`, `zero_extnd`) together with the ALU-computed address and the rs2 store data. Drives a request/grant/response data-memory port. Returns aligned, sign- or zero-extended load data to the writeback mux on the MEM source. One access is in flight at a time; the pipeline stalls on `lsu_busy_o`.

---
 rtl/sparrow_lsu_pkg.sv | 51 +++++
 rtl/sparrow_lsu_if.sv | 23 ++
 rtl/sparrow_lsu_align.sv | 32 +++
 rtl/sparrow_lsu.sv | 151 +++++++++++++++
 tb/tb_sparrow_lsu.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sparrow_lsu_pkg.sv
// Shared types and helpers for the sparrow load/store unit:
// access sizes, LSU FSM states, byte-enable and lane-replication rules.
package sparrow_lsu_pkg;

    // 2'b10 is deliberately unused and treated as an illegal size.
    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b11
    } mem_access_size_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    function automatic logic [3:0] be_gen(input mem_access_size_e size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            BYTE:      be = 4'b0001 << addr_lo;
            HALF_WORD: be = 4'b0011 << addr_lo;
            WORD:      be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            BYTE:      bad = 1'b0;
            HALF_WORD: bad = addr_lo[0];
            WORD:      bad = |addr_lo;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] wdata_replicate(input mem_access_size_e size, input logic [31:0] wdata);
        logic [31:0] rep;
        case (size)
            BYTE:      rep = {4{wdata[7:0]}};
            HALF_WORD: rep = {2{wdata[15:0]}};
            default:   rep = wdata;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/sparrow_lsu_if.sv
// Request/grant/response data-memory port between the LSU and data memory.
interface sparrow_lsu_if;

    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    modport master (
        output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i
    );

endinterface

// File: rtl/sparrow_lsu_align.sv
// Load data extraction: picks the byte or half-word addressed inside the
// fetched word and sign- or zero-extends it to 32 bits.
module sparrow_lsu_align
    import sparrow_lsu_pkg::*;
(
    input  logic [31:0]      rdata_i,
    input  logic [1:0]       addr_lo_i,
    input  mem_access_size_e size_i,
    input  logic             zero_extnd_i,
    output logic [31:0]      rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (size_i)
            BYTE:      rdata_o = {{24{~zero_extnd_i & byte_sel[7]}}, byte_sel};
            HALF_WORD: rdata_o = {{16{~zero_extnd_i & half_sel[15]}}, half_sel};
            default:   rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/sparrow_lsu.sv
// sparrow load/store unit: one access in flight, registered memory port,
// aligned and extended load data returned on completion.
module sparrow_lsu
    import sparrow_lsu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          lsu_req_i,
    input  logic          lsu_wr_i,
    input  logic [1:0]    lsu_size_i,
    input  logic          lsu_zero_extnd_i,
    input  logic [31:0]   lsu_addr_i,
    input  logic [31:0]   lsu_wdata_i,
    output logic          lsu_busy_o,
    output logic          lsu_done_o,
    output logic [31:0]   lsu_rdata_o,
    output logic          lsu_err_o,
    sparrow_lsu_if.master mem
);

    lsu_state_e  state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic        zext_q, zext_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        err_q, err_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] load_ext;
    logic        accept_err;

    assign accept_err = misaligned(lsu_size_i, lsu_addr_i[1:0]);

    sparrow_lsu_align u_align (
        .rdata_i      (mem.data_rdata_i),
        .addr_lo_i    (addr_lo_q),
        .size_i       (mem_access_size_e'(size_q)),
        .zero_extnd_i (zext_q),
        .rdata_o      (load_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= LSU_IDLE;
            wr_q      <= 1'b0;
            size_q    <= 2'b00;
            zext_q    <= 1'b0;
            addr_lo_q <= 2'b00;
            err_q     <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= 4'b0000;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            size_q    <= size_d;
            zext_q    <= zext_d;
            addr_lo_q <= addr_lo_d;
            err_q     <= err_d;
            req_q     <= req_d;
            we_q      <= we_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: if (lsu_req_i) state_d = accept_err ? LSU_DONE : LSU_REQ;
            LSU_REQ:  if (mem.data_gnt_i) state_d = LSU_WAIT;
            LSU_WAIT: if (mem.data_rvalid_i) state_d = LSU_DONE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_comb begin
        wr_d       = wr_q;
        size_d     = size_q;
        zext_d     = zext_q;
        addr_lo_d  = addr_lo_q;
        err_d      = err_q;
        req_d      = req_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        lsu_busy_o = 1'b0;
        lsu_done_o = 1'b0;
        lsu_err_o  = 1'b0;

        case (state_q)
            LSU_IDLE: begin
                lsu_busy_o = lsu_req_i;
                if (lsu_req_i) begin
                    wr_d      = lsu_wr_i;
                    size_d    = lsu_size_i;
                    zext_d    = lsu_zero_extnd_i;
                    addr_lo_d = lsu_addr_i[1:0];
                    err_d     = accept_err;
                    rdata_d   = 32'd0;
                    // A faulting access never touches memory.
                    if (!accept_err) begin
                        req_d   = 1'b1;
                        we_d    = lsu_wr_i;
                        be_d    = be_gen(mem_access_size_e'(lsu_size_i), lsu_addr_i[1:0]);
                        addr_d  = {lsu_addr_i[31:2], 2'b00};
                        wdata_d = wdata_replicate(mem_access_size_e'(lsu_size_i), lsu_wdata_i);
                    end
                end
            end
            LSU_REQ: begin
                lsu_busy_o = 1'b1;
                if (mem.data_gnt_i) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = 4'b0000;
                    addr_d  = 32'd0;
                    wdata_d = 32'd0;
                end
            end
            LSU_WAIT: begin
                lsu_busy_o = 1'b1;
                // The response also acknowledges stores, which return zero.
                if (mem.data_rvalid_i) rdata_d = wr_q ? 32'd0 : load_ext;
            end
            default: begin
                lsu_done_o = ~err_q;
                lsu_err_o  = err_q;
            end
        endcase
    end

    assign lsu_rdata_o      = rdata_q;
    assign mem.data_req_o   = req_q;
    assign mem.data_we_o    = we_q;
    assign mem.data_be_o    = be_q;
    assign mem.data_addr_o  = addr_q;
    assign mem.data_wdata_o = wdata_q;

endmodule

// File: tb/tb_sparrow_lsu.sv
// Bench for sparrow_lsu: directed vector table, hand-written reset and
// back-to-back sequences, and randomized accesses against a reference model.
module tb_sparrow_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_req_i;
    logic        lsu_wr_i;
    logic [1:0]  lsu_size_i;
    logic        lsu_zero_extnd_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_busy_o;
    logic        lsu_done_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_err_o;

    sparrow_lsu_if mem ();

    sparrow_lsu dut (
        .clk              (clk),
        .reset            (reset),
        .lsu_req_i        (lsu_req_i),
        .lsu_wr_i         (lsu_wr_i),
        .lsu_size_i       (lsu_size_i),
        .lsu_zero_extnd_i (lsu_zero_extnd_i),
        .lsu_addr_i       (lsu_addr_i),
        .lsu_wdata_i      (lsu_wdata_i),
        .lsu_busy_o       (lsu_busy_o),
        .lsu_done_o       (lsu_done_o),
        .lsu_rdata_o      (lsu_rdata_o),
        .lsu_err_o        (lsu_err_o),
        .mem              (mem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        zext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem;
        int          gd;
        int          rd;
        logic        e_err;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    int cyc_cnt = 0;
    int done_times[$];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
    always @(negedge clk) if (lsu_done_o === 1'b1) done_times.push_back(cyc_cnt);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic zext,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] memw,
                                input int gd, input int rd, input logic e_err, input logic [3:0] e_be,
                                input logic [31:0] e_addr, input logic [31:0] e_wdata, input logic [31:0] e_rdata);
        vec_t v;
        v.wr = wr; v.size = size; v.zext = zext; v.addr = addr; v.wdata = wdata; v.mem = memw;
        v.gd = gd; v.rd = rd; v.e_err = e_err; v.e_be = e_be; v.e_addr = e_addr;
        v.e_wdata = e_wdata; v.e_rdata = e_rdata;
        return v;
    endfunction

    // Reference: sizes 00/01/11 are 1/2/4 bytes, an access is legal when the
    // address is a multiple of its size, each lane i carries store byte i%n.
    function automatic vec_t model(input logic wr, input logic [1:0] size, input logic zext,
                                   input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] memw,
                                   input int gd, input int rd);
        vec_t v;
        int nb;
        int a;
        logic [63:0] val;
        logic [63:0] mask;
        v = mk(wr, size, zext, addr, wdata, memw, gd, rd, 1'b0, 4'b0, addr & 32'hFFFF_FFFC, 32'd0, 32'd0);
        case (size)
            2'b00:   nb = 1;
            2'b01:   nb = 2;
            2'b11:   nb = 4;
            default: nb = 0;
        endcase
        a = int'(addr[1:0]);
        v.e_err = (nb == 0) ? 1'b1 : ((a % nb) != 0);
        if (!v.e_err) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= a && i < a + nb) v.e_be[i] = 1'b1;
                v.e_wdata[8*i +: 8] = wdata[8*(i % nb) +: 8];
            end
            val  = 64'(memw) >> (8 * a);
            mask = (64'd1 << (8 * nb)) - 64'd1;
            val  = val & mask;
            if (!zext && val[8*nb-1]) val = val | ~mask;
            v.e_rdata = wr ? 32'd0 : val[31:0];
        end
        return v;
    endfunction

    // Starts at a negedge; acts as the memory; returns at the negedge after
    // completion (or at the completion negedge when keep holds the request).
    task automatic run_access(input vec_t v, input int extra, input bit keep);
        int cyc = 0, gcnt = 0, rcnt = 0, phase = 0;
        int done_n = 0, err_n = 0, done_cyc = -1, err_cyc = -1;
        bit seen_req = 0, req_after_gnt = 0;
        logic [3:0]  be0 = 4'b0;
        logic [31:0] a0 = 32'd0, w0 = 32'd0, rd = 32'd0;
        logic        we0 = 1'b0;
        lsu_req_i        = 1'b1;
        lsu_wr_i         = v.wr;
        lsu_size_i       = v.size;
        lsu_zero_extnd_i = v.zext;
        lsu_addr_i       = v.addr;
        lsu_wdata_i      = v.wdata;
        if (extra == 0) begin
            #1;
            check("busy_on_req", 32'(lsu_busy_o), 32'd1);
        end
        while (done_n + err_n == 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            mem.data_gnt_i    = 1'b0;
            mem.data_rvalid_i = 1'b0;
            mem.data_rdata_i  = $urandom;
            if (lsu_done_o) begin done_n++; done_cyc = cyc; rd = lsu_rdata_o; end
            if (lsu_err_o) begin err_n++; err_cyc = cyc; end
            if (phase == 0 && mem.data_req_o) begin
                if (!seen_req) begin
                    be0 = mem.data_be_o; a0 = mem.data_addr_o; w0 = mem.data_wdata_o; we0 = mem.data_we_o;
                end else begin
                    check("stall_be", 32'(mem.data_be_o), 32'(be0));
                    check("stall_addr", mem.data_addr_o, a0);
                    check("stall_wdata", mem.data_wdata_o, w0);
                    check("stall_busy", 32'(lsu_busy_o), 32'd1);
                end
                seen_req = 1;
                if (gcnt == v.gd) begin
                    mem.data_gnt_i = 1'b1;
                    phase = 1;
                end else begin
                    gcnt++;
                    mem.data_rvalid_i = 1'($urandom_range(0, 1));
                end
            end else if (phase == 1) begin
                if (mem.data_req_o) req_after_gnt = 1;
                rcnt++;
                if (rcnt == v.rd) begin
                    mem.data_rvalid_i = 1'b1;
                    mem.data_rdata_i  = v.mem;
                    phase = 2;
                end
            end
        end
        check("completed", 32'(done_n + err_n), 32'd1);
        check("err_pulse", 32'(err_n), 32'(v.e_err));
        check("done_pulse", 32'(done_n), 32'(!v.e_err));
        if (v.e_err) begin
            check("err_latency", 32'(err_cyc), 32'(1 + extra));
            check("no_mem_req", 32'(seen_req), 32'd0);
        end else begin
            check("done_latency", 32'(done_cyc), 32'(2 + v.gd + v.rd + extra));
            check("be", 32'(be0), 32'(v.e_be));
            check("mem_addr", a0, v.e_addr);
            check("mem_wdata", w0, v.e_wdata);
            check("we", 32'(we0), 32'(v.wr));
            check("rdata", rd, v.e_rdata);
            check("req_dropped", 32'(req_after_gnt), 32'd0);
        end
        if (!keep) begin
            lsu_req_i = 1'b0;
            @(negedge clk);
            mem.data_gnt_i    = 1'b0;
            mem.data_rvalid_i = 1'b0;
            check("idle_done", 32'(lsu_done_o), 32'd0);
            check("idle_err", 32'(lsu_err_o), 32'd0);
            check("idle_busy", 32'(lsu_busy_o), 32'd0);
            check("idle_req", 32'(mem.data_req_o), 32'd0);
        end
    endtask

    initial begin
        vec_t        tbl[12];
        vec_t        v;
        int          r;
        int          gap;
        logic [1:0]  sz;
        logic [31:0] ad;

        // size codes: 00 byte, 01 half, 11 word, 10 illegal
        tbl[0]  = mk(0, 2'b00, 0, 32'h1003, 32'h0, 32'h80FF_1234, 0, 1, 0, 4'b1000, 32'h1000, 32'h0, 32'hFFFF_FF80);
        tbl[1]  = mk(0, 2'b00, 1, 32'h1003, 32'h0, 32'h80FF_1234, 1, 2, 0, 4'b1000, 32'h1000, 32'h0, 32'h0000_0080);
        tbl[2]  = mk(1, 2'b01, 0, 32'h2002, 32'h0000_ABCD, 32'hFFFF_FFFF, 0, 1, 0, 4'b1100, 32'h2000, 32'hABCD_ABCD, 32'h0);
        tbl[3]  = mk(0, 2'b11, 0, 32'h3001, 32'h0, 32'h0, 0, 1, 1, 4'b0, 32'h0, 32'h0, 32'h0);
        tbl[4]  = mk(0, 2'b01, 0, 32'h3001, 32'h0, 32'h0, 0, 1, 1, 4'b0, 32'h0, 32'h0, 32'h0);
        tbl[5]  = mk(0, 2'b01, 0, 32'h3002, 32'h0, 32'h80FF_1234, 0, 1, 0, 4'b1100, 32'h3000, 32'h0, 32'hFFFF_80FF);
        tbl[6]  = mk(0, 2'b11, 0, 32'h4000, 32'h0, 32'hDEAD_BEEF, 5, 1, 0, 4'b1111, 32'h4000, 32'h0, 32'hDEAD_BEEF);
        tbl[7]  = mk(0, 2'b10, 0, 32'h5000, 32'h0, 32'h0, 0, 1, 1, 4'b0, 32'h0, 32'h0, 32'h0);
        tbl[8]  = mk(1, 2'b00, 0, 32'h5001, 32'h1234_5678, 32'h0, 2, 3, 0, 4'b0010, 32'h5000, 32'h7878_7878, 32'h0);
        tbl[9]  = mk(0, 2'b01, 1, 32'h6002, 32'h0, 32'hFEDC_0000, 0, 1, 0, 4'b1100, 32'h6000, 32'h0, 32'h0000_FEDC);
        tbl[10] = mk(1, 2'b11, 0, 32'h7004, 32'hCAFE_F00D, 32'h0, 1, 1, 0, 4'b1111, 32'h7004, 32'hCAFE_F00D, 32'h0);
        tbl[11] = mk(0, 2'b00, 0, 32'h8002, 32'h0, 32'h0055_0000, 0, 1, 0, 4'b0100, 32'h8000, 32'h0, 32'h0000_0055);

        reset = 1'b1;
        lsu_req_i = 1'b0; lsu_wr_i = 1'b0; lsu_size_i = 2'b00; lsu_zero_extnd_i = 1'b0;
        lsu_addr_i = 32'd0; lsu_wdata_i = 32'd0;
        mem.data_gnt_i = 1'b0; mem.data_rvalid_i = 1'b0; mem.data_rdata_i = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(lsu_busy_o), 32'd0);
        check("rst_done", 32'(lsu_done_o), 32'd0);
        check("rst_err", 32'(lsu_err_o), 32'd0);
        check("rst_rdata", lsu_rdata_o, 32'd0);
        check("rst_req", 32'(mem.data_req_o), 32'd0);
        check("rst_we", 32'(mem.data_we_o), 32'd0);
        check("rst_be", 32'(mem.data_be_o), 32'd0);
        check("rst_addr", mem.data_addr_o, 32'd0);
        check("rst_wdata", mem.data_wdata_o, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) run_access(tbl[i], 0, 0);

        // Back-to-back with the request held through the done cycle.
        done_times.delete();
        run_access(mk(0, 2'b11, 0, 32'h10, 32'h0, 32'h1122_3344, 0, 1, 0, 4'b1111, 32'h10, 32'h0, 32'h1122_3344), 0, 1);
        run_access(mk(1, 2'b00, 0, 32'h11, 32'h0000_00AB, 32'h0, 0, 1, 0, 4'b0010, 32'h10, 32'hABAB_ABAB, 32'h0), 1, 0);
        check("b2b_pulses", 32'(done_times.size()), 32'd2);
        gap = (done_times.size() >= 2) ? done_times[1] - done_times[0] : -1;
        check("b2b_spacing", 32'(gap), 32'd4);

        // Reset while waiting for the response, then a late response.
        lsu_req_i = 1'b1; lsu_wr_i = 1'b0; lsu_size_i = 2'b11; lsu_addr_i = 32'h40;
        @(negedge clk);
        check("mid_req", 32'(mem.data_req_o), 32'd1);
        mem.data_gnt_i = 1'b1;
        @(negedge clk);
        mem.data_gnt_i = 1'b0;
        check("mid_busy_wait", 32'(lsu_busy_o), 32'd1);
        reset = 1'b1;
        lsu_req_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_req", 32'(mem.data_req_o), 32'd0);
        check("mid_rst_busy", 32'(lsu_busy_o), 32'd0);
        check("mid_rst_done", 32'(lsu_done_o), 32'd0);
        check("mid_rst_rdata", lsu_rdata_o, 32'd0);
        mem.data_rvalid_i = 1'b1;
        mem.data_rdata_i  = 32'h55AA_55AA;
        @(negedge clk);
        mem.data_rvalid_i = 1'b0;
        check("late_rv_done", 32'(lsu_done_o), 32'd0);
        check("late_rv_busy", 32'(lsu_busy_o), 32'd0);
        check("late_rv_rdata", lsu_rdata_o, 32'd0);
        run_access(mk(0, 2'b11, 0, 32'h0, 32'h0, 32'h0BAD_F00D, 0, 1, 0, 4'b1111, 32'h0, 32'h0, 32'h0BAD_F00D), 0, 0);

        for (int k = 0; k < 150; k++) begin
            r  = int'($urandom_range(0, 9));
            sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b11 : 2'b10;
            ad = $urandom;
            if ($urandom_range(0, 3) != 0)
                ad[1:0] = (sz == 2'b00) ? ad[1:0] : (sz == 2'b01) ? {ad[1], 1'b0} : 2'b00;
            v = model(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, $urandom,
                      int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
            run_access(v, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
